ptp_extts_evq: RTL

- Event queue directly downstream of the PTP external-timestamp latcher, in the same clk domain as its status outputs.
- Detects each new latched timestamp (rising edge of the latcher's locked) and pushes it, with a sequence number, into a small FIFO.
- Pulses arm back to the latcher so it re-arms, and presents queued events to the CSR block over a valid/ready interface.
- Tracks overflow and PTP clock-step events as sticky status.

---
 rtl/ptp_extts_evq_pkg.sv | 19 +
 rtl/ptp_extts_evq_if.sv | 16 +
 rtl/ptp_extts_evq_ram.sv | 22 ++
 rtl/ptp_extts_evq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ptp_extts_evq_pkg.sv
// Shared PTP external-timestamp definitions: timestamp field layout and default widths.
package ptp_extts_evq_pkg;

  localparam int unsigned TS_S_W    = 48;
  localparam int unsigned TS_NS_W   = 30;
  localparam int unsigned TS_FNS_W  = 16;
  localparam int unsigned TS_W      = 96;
  localparam int unsigned SEQ_W_DEF = 16;
  localparam int unsigned OVF_W_DEF = 16;

  // Timestamp as produced by the latcher: {s, 2'b0, ns, fns}
  typedef struct packed {
    logic [TS_S_W-1:0]   s;
    logic [1:0]          rsvd;
    logic [TS_NS_W-1:0]  ns;
    logic [TS_FNS_W-1:0] fns;
  } ptp_ts_t;

endpackage

// File: rtl/ptp_extts_evq_if.sv
// Valid/ready read channel carrying queued timestamp events to the CSR block.
interface ptp_extts_evq_if
  import ptp_extts_evq_pkg::*;
#(
  parameter int unsigned SEQ_W = SEQ_W_DEF
) ();

  logic             rd_valid;
  logic             rd_ready;
  logic [TS_W-1:0]  rd_ts;
  logic [SEQ_W-1:0] rd_seq;

  modport master (output rd_valid, output rd_ts, output rd_seq, input rd_ready);
  modport slave  (input rd_valid, input rd_ts, input rd_seq, output rd_ready);

endinterface

// File: rtl/ptp_extts_evq_ram.sv
// Event storage: register array, synchronous write, asynchronous read.
module ptp_extts_evq_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 112
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_c_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/ptp_extts_evq.sv
// Timestamp event queue: detects new latched timestamps, queues them with a sequence
// number, re-arms the latcher and tracks overflow / clock-step status.
module ptp_extts_evq
  import ptp_extts_evq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = SEQ_W_DEF,
  parameter int unsigned OVF_W = OVF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [TS_W-1:0]          extts_ts,
  input  logic                     extts_locked,
  input  logic                     extts_step,
  output logic                     extts_arm,
  ptp_extts_evq_if.master          rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [OVF_W-1:0]         ovf_count,
  output logic                     step_seen
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = TS_W + SEQ_W;

  logic             locked_q, step_q, arm_q, rd_valid_q, overflow_q, step_seen_q;
  logic             arm_d, rd_valid_d, overflow_d, step_seen_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d, head_seq_q, head_seq_d;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [TS_W-1:0]  head_ts_q, head_ts_d;
  logic [ENT_W-1:0] ram_rdata;
  logic             ev, pop, room, push, drop;

  // Control: event detect, pointers, counters and sticky status
  always_comb begin
    ev   = enable & extts_locked & ~locked_q & ~flush;
    pop  = rd_valid_q & rd.rd_ready & ~flush;
    room = (level_q < LVL_W'(DEPTH)) | pop;
    push = ev & room;
    drop = ev & ~room;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    seq_d       = seq_q;
    overflow_d  = overflow_q;
    ovf_cnt_d   = ovf_cnt_q;
    step_seen_d = step_seen_q;
    arm_d       = ev;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      ovf_cnt_d   = '0;
      step_seen_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      // Sequence advances on dropped events too, leaving a visible gap
      if (ev) seq_d = seq_q + SEQ_W'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
      end
      if (extts_step && !step_q) step_seen_d = 1'b1;
    end

    rd_valid_d = (level_d != '0);
  end

  // Head register: bypass the incoming entry when it becomes the head
  always_comb begin
    head_ts_d  = head_ts_q;
    head_seq_d = head_seq_q;
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_ts_d  = extts_ts;
      head_seq_d = seq_q;
    end else if (rd_valid_d) begin
      {head_ts_d, head_seq_d} = ram_rdata;
    end
  end

  ptp_extts_evq_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (push),
    .waddr_i   (wr_ptr_q),
    .wdata_i   ({extts_ts, seq_q}),
    .raddr_i   (rd_ptr_d),
    .rdata_c_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      arm_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      step_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      seq_q       <= '0;
      ovf_cnt_q   <= '0;
      head_ts_q   <= '0;
      head_seq_q  <= '0;
    end else begin
      locked_q    <= extts_locked;
      step_q      <= extts_step;
      arm_q       <= arm_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      step_seen_q <= step_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      seq_q       <= seq_d;
      ovf_cnt_q   <= ovf_cnt_d;
      head_ts_q   <= head_ts_d;
      head_seq_q  <= head_seq_d;
    end
  end

  assign extts_arm   = arm_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_ts    = head_ts_q;
  assign rd.rd_seq   = head_seq_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign ovf_count   = ovf_cnt_q;
  assign step_seen   = step_seen_q;

endmodule
